// File: rtl/ins_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: widths, JAL opcode,
// FSM state encoding and a small opcode helper.
package ins_fetcher_pkg;

    localparam int INS_LEN = 32;
    localparam int PC_LEN  = 32;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    function automatic logic is_jal(input logic [6:0] opc);
        return opc == OPC_JAL;
    endfunction

endpackage

// File: rtl/ins_fetcher_if.sv
// Fetch port between the fetcher (master) and memory/icache (slave).
// mem_req/mem_addr: level request + address; mem_done/mem_ins: one-cycle reply.
interface ins_fetcher_if
    import ins_fetcher_pkg::*;
#(
    parameter int PC_W  = PC_LEN,
    parameter int INS_W = INS_LEN
);

    logic             mem_req;
    logic [PC_W-1:0]  mem_addr;
    logic             mem_done;
    logic [INS_W-1:0] mem_ins;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_done,
        input  mem_ins
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_done,
        output mem_ins
    );

endinterface

// File: rtl/ins_fetcher_jal_imm_decode.sv
// J-type immediate extraction with sign extension to PC_W bits.
// Ports: ins = instruction bits [31:12]; imm = sign-extended byte offset.
module ins_fetcher_jal_imm_decode #(
    parameter int PC_W = 32
) (
    input  logic [31:12]    ins,
    output logic [PC_W-1:0] imm
);

    logic [20:0] j;

    // imm[20|10:1|11|19:12] live in ins[31|30:21|20|19:12]
    assign j   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm = {{(PC_W-21){j[20]}}, j};

endmodule

// File: rtl/ins_fetcher.sv
// Fetch sequencer: owns the PC, issues one fetch at a time, pushes word+PC
// into the instruction queue, stalls on full, redirects on clear.
// Ports: clk, reset (async, high), ready (global enable), clear/clear_pc
// (redirect), full (queue), push/push_ins/push_pc (queue write),
// mem (ins_fetcher_if.master: mem_req, mem_addr, mem_done, mem_ins).
// Option: define FETCH_JAL_PREDICT_EN to follow JAL targets at push time.
module ins_fetcher
    import ins_fetcher_pkg::*;
#(
    parameter int              PC_W     = PC_LEN,
    parameter int              INS_W    = INS_LEN,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             clear,
    input  logic [PC_W-1:0]  clear_pc,
    input  logic             full,
    output logic             push,
    output logic [INS_W-1:0] push_ins,
    output logic [PC_W-1:0]  push_pc,
    ins_fetcher_if.master    mem
);

    localparam logic [PC_W-1:0] STEP = PC_W'(4);

    state_t           state, state_n;
    logic [PC_W-1:0]  pc, pc_n, pc_seq;
    logic             push_n;
    logic [INS_W-1:0] push_ins_n;
    logic [PC_W-1:0]  push_pc_n;
    logic             req, req_n;
    logic [PC_W-1:0]  addr, addr_n;
    logic [INS_W-1:0] hold, hold_n;

    assign mem.mem_req  = req;
    assign mem.mem_addr = addr;

`ifdef FETCH_JAL_PREDICT_EN
    logic [INS_W-1:0] word;
    logic [PC_W-1:0]  jimm;

    // the word being pushed this cycle: held word in HOLD, else the reply
    assign word = (state == ST_HOLD) ? hold : mem.mem_ins;

    ins_fetcher_jal_imm_decode #(.PC_W(PC_W)) u_jimm (
        .ins (word[31:12]),
        .imm (jimm)
    );

    assign pc_seq = is_jal(word[6:0]) ? pc + jimm : pc + STEP;
`else
    assign pc_seq = pc + STEP;
`endif

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        push_n     = 1'b0;
        push_ins_n = push_ins;
        push_pc_n  = push_pc;
        req_n      = req;
        addr_n     = addr;
        hold_n     = hold;
        unique case (state)
            ST_IDLE: begin
                if (clear) begin
                    pc_n = clear_pc;
                end else if (!full) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (clear) begin
                    pc_n = clear_pc;
                    if (mem.mem_done) begin
                        req_n   = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        // request cannot be cancelled; swallow its reply
                        state_n = ST_DISCARD;
                    end
                end else if (mem.mem_done) begin
                    req_n = 1'b0;
                    if (full) begin
                        hold_n  = mem.mem_ins;
                        state_n = ST_HOLD;
                    end else begin
                        push_n     = 1'b1;
                        push_ins_n = mem.mem_ins;
                        push_pc_n  = pc;
                        pc_n       = pc_seq;
                        state_n    = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (clear) begin
                    pc_n    = clear_pc;
                    state_n = ST_IDLE;
                end else if (!full) begin
                    push_n     = 1'b1;
                    push_ins_n = hold;
                    push_pc_n  = pc;
                    pc_n       = pc_seq;
                    state_n    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (clear) begin
                    pc_n = clear_pc;
                end
                if (mem.mem_done) begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            push     <= 1'b0;
            push_ins <= '0;
            push_pc  <= '0;
            req      <= 1'b0;
            addr     <= '0;
            hold     <= '0;
        end else if (ready) begin
            state    <= state_n;
            pc       <= pc_n;
            push     <= push_n;
            push_ins <= push_ins_n;
            push_pc  <= push_pc_n;
            req      <= req_n;
            addr     <= addr_n;
            hold     <= hold_n;
        end
    end

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed cycle-table bench for ins_fetcher plus a mid-fetch reset sequence.
// Build with FETCH_JAL_PREDICT_EN defined to check the JAL-follow option.
module tb_ins_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] clear_pc = '0;
    logic        full = 1'b1;
    logic        push;
    logic [31:0] push_ins;
    logic [31:0] push_pc;

    int n_cmp = 0;
    int n_err = 0;

    ins_fetcher_if #(.PC_W(32), .INS_W(32)) mif ();

    ins_fetcher #(.PC_W(32), .INS_W(32), .RESET_PC(32'h0)) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .clear    (clear),
        .clear_pc (clear_pc),
        .full     (full),
        .push     (push),
        .push_ins (push_ins),
        .push_pc  (push_pc),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        clr;
        logic [31:0] cpc;
        logic        full;
        logic        done;
        logic [31:0] ins;
        logic        e_push;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_ppc;
        logic [31:0] e_pins;
    } vec_t;

    vec_t tv[$];

    localparam logic [31:0] I0  = 32'h11100013;
    localparam logic [31:0] I1  = 32'h22200013;
    localparam logic [31:0] I2  = 32'h33300013;
    localparam logic [31:0] I3  = 32'h44400013;
    localparam logic [31:0] I4  = 32'h55500013;
    localparam logic [31:0] I5  = 32'h66600013;
    localparam logic [31:0] I6  = 32'h6a600013;
    localparam logic [31:0] I7  = 32'h77700013;
    localparam logic [31:0] I8  = 32'h88800013;
    localparam logic [31:0] I9  = 32'h99900013;
    localparam logic [31:0] I10 = 32'haaa00013;
    // jal x1, +16
    localparam logic [31:0] JW  = 32'h010000ef;
`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [31:0] JN  = 32'h00000030;
`else
    localparam logic [31:0] JN  = 32'h00000024;
`endif
    localparam logic [31:0] WR  = 32'hfffffffc;

    task automatic v(input logic rdy, input logic clr,
                     input logic [31:0] cpc, input logic fl,
                     input logic dn, input logic [31:0] ins,
                     input logic ep, input logic er,
                     input logic [31:0] ea, input logic [31:0] epc,
                     input logic [31:0] ein);
        vec_t r;
        r.rdy = rdy; r.clr = clr; r.cpc = cpc; r.full = fl;
        r.done = dn; r.ins = ins; r.e_push = ep; r.e_req = er;
        r.e_addr = ea; r.e_ppc = epc; r.e_pins = ein;
        tv.push_back(r);
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h",
                     nm, row, act, exp);
        end
    endtask

    initial begin
        mif.mem_done = 1'b0;
        mif.mem_ins  = '0;

        // basic fetch: 0, 4, 8
        v(1,0,0,0,0,0,    0,1,0,0,0);
        v(1,0,0,0,0,0,    0,1,0,0,0);
        v(1,0,0,0,1,I0,   1,0,0,0,I0);
        v(1,0,0,0,0,0,    0,1,4,0,I0);
        v(1,0,0,0,0,0,    0,1,4,0,I0);
        v(1,0,0,0,1,I1,   1,0,4,4,I1);
        v(1,0,0,0,0,0,    0,1,8,4,I1);
        v(1,0,0,0,0,0,    0,1,8,4,I1);
        v(1,0,0,0,1,I2,   1,0,8,8,I2);
        // full stall at 0xC
        v(1,0,0,0,0,0,    0,1,12,8,I2);
        v(1,0,0,1,0,0,    0,1,12,8,I2);
        v(1,0,0,1,1,I3,   0,0,12,8,I2);
        for (int i = 0; i < 4; i++)
            v(1,0,0,1,0,0, 0,0,12,8,I2);
        v(1,0,0,0,0,0,    1,0,12,12,I3);
        v(1,0,0,0,0,0,    0,1,16,12,I3);
        // clear in WAIT
        v(1,1,32'h100,0,0,0,  0,1,16,12,I3);
        v(1,0,0,0,1,I4,   0,0,16,12,I3);
        v(1,0,0,0,0,0,    0,1,32'h100,12,I3);
        // clear with mem_done
        v(1,0,0,0,0,0,    0,1,32'h100,12,I3);
        v(1,1,32'h200,0,1,I5, 0,0,32'h100,12,I3);
        v(1,0,0,0,0,0,    0,1,32'h200,12,I3);
        // clear in HOLD
        v(1,0,0,1,1,I6,   0,0,32'h200,12,I3);
        v(1,1,32'h300,1,0,0,  0,0,32'h200,12,I3);
        v(1,0,0,0,0,0,    0,1,32'h300,12,I3);
        // ready gating mid-WAIT; clear/full ignored while ready=0
        for (int i = 0; i < 4; i++)
            v(0,1,32'h400,1,0,0, 0,1,32'h300,12,I3);
        v(1,0,0,0,1,I7,   1,0,32'h300,32'h300,I7);
        v(1,0,0,0,0,0,    0,1,32'h304,32'h300,I7);
        v(1,0,0,0,0,0,    0,1,32'h304,32'h300,I7);
        v(1,0,0,0,1,I8,   1,0,32'h304,32'h304,I8);
        v(0,0,0,0,0,0,    1,0,32'h304,32'h304,I8);
        v(1,0,0,0,0,0,    0,1,32'h308,32'h304,I8);
        // redirect to 0x20 and fetch a JAL
        v(1,1,32'h20,0,0,0,   0,1,32'h308,32'h304,I8);
        v(1,0,0,0,1,I5,   0,0,32'h308,32'h304,I8);
        v(1,0,0,0,0,0,    0,1,32'h20,32'h304,I8);
        v(1,0,0,0,1,JW,   1,0,32'h20,32'h20,JW);
        v(1,0,0,0,0,0,    0,1,JN,32'h20,JW);
        // pc wrap at top of address space
        v(1,1,WR,0,0,0,   0,1,JN,32'h20,JW);
        v(1,0,0,0,1,I4,   0,0,JN,32'h20,JW);
        v(1,0,0,0,0,0,    0,1,WR,32'h20,JW);
        v(1,0,0,0,1,I9,   1,0,WR,WR,I9);
        v(1,0,0,0,0,0,    0,1,0,WR,I9);
        v(1,0,0,0,1,I10,  1,0,0,0,I10);
        // clear in IDLE: no request that cycle
        v(1,1,32'h500,0,0,0,  0,0,0,0,I10);
        v(1,0,0,0,0,0,    0,1,32'h500,0,I10);
        // repeated clear in DISCARD keeps the last target
        v(1,1,32'h600,0,0,0,  0,1,32'h500,0,I10);
        v(1,1,32'h700,0,0,0,  0,1,32'h500,0,I10);
        v(1,0,0,0,1,I1,   0,0,32'h500,0,I10);
        v(1,0,0,0,0,0,    0,1,32'h700,0,I10);

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_push", -1, 32'(push), 32'h0);
        chk("rst_req", -1, 32'(mif.mem_req), 32'h0);
        chk("rst_addr", -1, mif.mem_addr, 32'h0);
        chk("rst_ppc", -1, push_pc, 32'h0);
        chk("rst_pins", -1, push_ins, 32'h0);
        reset = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk);
            ready        = tv[i].rdy;
            clear        = tv[i].clr;
            clear_pc     = tv[i].cpc;
            full         = tv[i].full;
            mif.mem_done = tv[i].done;
            mif.mem_ins  = tv[i].ins;
            @(posedge clk);
            #1;
            chk("push", i, 32'(push), 32'(tv[i].e_push));
            chk("mem_req", i, 32'(mif.mem_req), 32'(tv[i].e_req));
            chk("mem_addr", i, mif.mem_addr, tv[i].e_addr);
            chk("push_pc", i, push_pc, tv[i].e_ppc);
            chk("push_ins", i, push_ins, tv[i].e_pins);
        end

        // async reset while a fetch is outstanding
        @(negedge clk);
        ready        = 1'b1;
        clear        = 1'b0;
        full         = 1'b0;
        mif.mem_done = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", -2, 32'(mif.mem_req), 32'h0);
        chk("arst_addr", -2, mif.mem_addr, 32'h0);
        chk("arst_ppc", -2, push_pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_req", -2, 32'(mif.mem_req), 32'h1);
        chk("post_rst_addr", -2, mif.mem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ins_fetcher.md
Name: ins_fetcher

Overview:
- Front-end sequencer that owns the fetch PC and feeds the instruction queue.
- Issues one instruction-fetch request at a time to the memory/icache port, then pushes the returned word and its PC into the queue.
- Throttles on queue `full`. On `clear` (mispredict/flush) it redirects the PC and discards any in-flight fetch.

Parameters:
- PC_W, 32, width of PC and fetch address
- INS_W, 32, instruction width
- RESET_PC, 32'h0, PC loaded on reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- ready  in  1  global enable; when 0 all registers hold
- clear  in  1  flush/redirect request from commit
- clear_pc  in  PC_W  redirect target, valid with clear
- full  in  1  instruction queue full (registered by queue)
- push  out  1  push one entry into queue (registered)
- push_ins  out  INS_W  instruction pushed
- push_pc  out  PC_W  PC of pushed instruction
- mem_req  out  1  fetch request, level, held until mem_done
- mem_addr  out  PC_W  fetch address, stable while mem_req=1
- mem_done  in  1  one-cycle pulse: mem_ins valid
- mem_ins  in  INS_W  fetched word

Behaviour:
- Reset (async, reset=1) forces the following values:
  - pc=RESET_PC, state=IDLE
  - push=0, mem_req=0, mem_addr=0, push_ins=0, push_pc=0
  - hold register cleared
- All state updates occur only when ready=1. When ready=0, everything holds, including push. The queue ignores push while ready=0, so one pulse equals exactly one push over ready cycles.
- push defaults to 0 every ready cycle unless set below.
- FSM states are IDLE, WAIT, HOLD and DISCARD.
  - IDLE:
    - if clear: pc<=clear_pc, stay IDLE, no request.
    - else if !full: mem_req<=1, mem_addr<=pc, go WAIT.
  - WAIT:
    - if clear and !mem_done: pc<=clear_pc, go DISCARD (mem_req stays 1; the request cannot be cancelled).
    - if clear and mem_done: mem_req<=0, pc<=clear_pc, drop word, go IDLE.
    - if mem_done and !full: push<=1, push_ins<=mem_ins, push_pc<=pc, pc<=pc+4, mem_req<=0, go IDLE.
    - if mem_done and full: latch mem_ins into hold register, mem_req<=0, go HOLD.
  - HOLD:
    - if clear: drop held word, pc<=clear_pc, go IDLE.
    - else if !full: push<=1 with held word and pc, pc<=pc+4, go IDLE.
  - DISCARD:
    - wait for mem_done, drop word, mem_req<=0, go IDLE.
    - a further clear while in DISCARD updates pc to the new clear_pc only.
- Latency:
  - request issued cycle t (mem_req visible t+1); mem_done at cycle d; push visible d+1.
  - Minimum 3 cycles per instruction, since IDLE is always re-entered between fetches.
- Boundaries:
  - The queue's full is registered after its push; one push per ≥3 cycles guarantees full is current when sampled.
  - pc+4 wraps modulo 2^PC_W.
  - clear has priority over every other event in the same cycle. A push pulse already registered in the clear cycle is harmless, because the queue's clear has priority over push.
  - reset mid-WAIT abandons the request. Memory must tolerate mem_req dropping without mem_done.

Optional Feature:
- Macro: FETCH_JAL_PREDICT_EN.
- With the macro defined, a pushed word with opcode[6:0]=7'b1101111 (JAL) sets pc<=push_pc+sext(J-imm) instead of pc+4. The imm is decoded combinationally from the word being pushed.
- Without the macro, the next PC is always pc+4; jumps are resolved by clear from commit.

Decomposition:
- Existing shared definitions header (def.v): INS_LEN, PC_LEN ranges, the JAL opcode constant, and FSM state encodings (2-bit IDLE/WAIT/HOLD/DISCARD).
- One natural sub-module, jal_imm_decode: combinational J-type immediate extraction plus sign-extension, instantiated only under FETCH_JAL_PREDICT_EN.

Test Plan:
- Basic fetch:
  - Stimulus: reset, RESET_PC=0, full=0, memory returns mem_done 2 cycles after mem_req.
  - Required: addresses 0,4,8 requested in order; push pulses carry push_pc 0,4,8 with the matching words; exactly one push per fetch.
- Full stall:
  - Stimulus: full=1 while in WAIT when mem_done arrives; deassert full 5 cycles later.
  - Required: no push while full=1; push of the held word with the correct pc on the cycle after full=0; next request uses pc+4.
- Clear in WAIT:
  - Stimulus: clear=1, clear_pc=0x100 while mem_req is outstanding.
  - Required: returned word dropped (no push); next mem_addr=0x100.
- Clear coincident with mem_done, and clear in HOLD:
  - Required: no push in either case; next fetch at clear_pc.
- Ready gating:
  - Stimulus: ready=0 for 4 cycles mid-WAIT with mem_done held off.
  - Required: state, mem_addr and pc frozen; resumes correctly when ready returns.
- FETCH_JAL_PREDICT_EN:
  - Stimulus: fetch JAL with imm=+16 at pc 0x20.
  - Required: next mem_addr=0x30. With the macro undefined, next mem_addr=0x24.
